// File: rtl/lane_share_arbiter.sv
// Round-robin share of one multi-cycle combinational 12-bit lane between NREQ requesters.
// Optional build macro ARB_FIXED_PRIO_EN: lowest-index valid requester always wins.
module lane_share_arbiter #(
  parameter int NREQ   = 3,
  parameter int SETTLE = 2,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*12-1:0]   req_A,
  input  logic [NREQ*12-1:0]   req_B,
  output logic [11:0]          lane_A,
  output logic [11:0]          lane_B,
  input  logic [11:0]          lane_C,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [11:0]          rsp_C,
  output logic                 busy
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]      state;
  logic [CNT_W-1:0] cnt;
  logic [ID_W-1:0] grant_id;
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic            accept;

`ifndef ARB_FIXED_PRIO_EN
  logic [ID_W-1:0] rr_ptr;
`endif

  // Search starts at rr_ptr and wraps; fixed-priority build always starts at 0.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = (int'(rr_ptr) + k) % NREQ;
`endif
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = ID_W'(cand);
      end
    end
  end

  // Grant is only offered out of reset and in IDLE.
  assign accept    = rst_n && (state == S_IDLE) && win_found;
  assign req_ready = accept ? (NREQ'(1) << win_id) : '0;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      grant_id  <= '0;
      lane_A    <= '0;
      lane_B    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_C     <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lane_A   <= req_A[12*win_id +: 12];
            lane_B   <= req_B[12*win_id +: 12];
            grant_id <= win_id;
            cnt      <= CNT_LOAD;
            state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) state <= S_CAPTURE;
          else           cnt   <= cnt - 1'b1;
        end
        S_CAPTURE: begin
          rsp_C     <= lane_C;
          rsp_id    <= grant_id;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr    <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
`endif
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_share_arbiter.sv
// Bench for lane_share_arbiter: transaction-level model plus a lane netlist model that
// drives garbage on lane_C until the lane operands have been stable for SETTLE cycles.
module tb_lane_share_arbiter;
  localparam int NREQ   = 3;
  localparam int SETTLE = 2;
  localparam int ID_W   = 2;
  localparam int W      = ID_W + 12;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*12-1:0]  req_A, req_B;
  logic [11:0]         lane_A, lane_B, lane_C;
  logic                rsp_valid, rsp_ready, busy;
  logic [ID_W-1:0]     rsp_id;
  logic [11:0]         rsp_C;

  lane_share_arbiter #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .lane_A(lane_A), .lane_B(lane_B), .lane_C(lane_C),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_C(rsp_C),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- counters and check helper ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- lane netlist model ----------------
  function automatic logic [11:0] lane_f(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] c;
    c[0] = ~a[0];
    for (int i = 1; i < 6; i++) c[i] = ~b[i];
    for (int i = 6; i < 12; i++)
      c[i] = ~((a[i] | b[i]) & (a[i-6] | b[i-6]) & (a[i-5] | b[i-5]));
    return c;
  endfunction

  int          age = 0;
  logic [23:0] prev_lane = '0;
  initial lane_C = '0;

  // Result is only trustworthy once operands have been stable for more than SETTLE cycles.
  always @(posedge clk) begin
    #1;
    if ({lane_A, lane_B} !== prev_lane) age = 1;
    else if (age < 1000) age++;
    prev_lane = {lane_A, lane_B};
    lane_C = (age > SETTLE) ? lane_f(lane_A, lane_B) : 12'($urandom);
  end

  // ---------------- behavioural model + scoreboard ----------------
  logic [W-1:0]    exp_q[$];
  logic [ID_W-1:0] hs_ids[$];
  logic [11:0]     hs_c[$];
  int              rr_m = 0;
  int              cyc = 0;
  int              rsp_at = 0;
  logic [11:0]     lane_a_m = '0, lane_b_m = '0;

  always @(negedge clk) begin
    int w;
    logic [NREQ-1:0] exp_ready;
    logic exp_rv;
    if (!rst_n) begin
      exp_q.delete();
      rr_m = 0; lane_a_m = '0; lane_b_m = '0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_lane", {lane_A, lane_B}, 0);
      chk("rst_rsp", {rsp_id, rsp_C}, 0);
    end else begin
      w = -1;
      if (exp_q.size() == 0)
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req_valid[(rr_m + k) % NREQ]) w = (rr_m + k) % NREQ;
      exp_ready = (w >= 0) ? NREQ'(1) << w : '0;
      exp_rv = (exp_q.size() != 0) && (cyc >= rsp_at);
      chk("req_ready", req_ready, exp_ready);
      chk("busy", busy, exp_q.size() != 0);
      chk("lane_A", lane_A, lane_a_m);
      chk("lane_B", lane_B, lane_b_m);
      chk("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) chk("rsp_id_C", {rsp_id, rsp_C}, exp_q[0]);
      if (rsp_valid && rsp_ready) begin
        hs_ids.push_back(rsp_id);
        hs_c.push_back(rsp_C);
      end
      if (w >= 0) begin
        lane_a_m = req_A[12*w +: 12];
        lane_b_m = req_B[12*w +: 12];
        exp_q.push_back({ID_W'(w), lane_f(lane_a_m, lane_b_m)});
        rsp_at = cyc + SETTLE + 2;
      end else if (exp_rv && rsp_ready) begin
`ifdef ARB_FIXED_PRIO_EN
        rr_m = 0;
`else
        rr_m = (int'(exp_q[0][W-1:12]) + 1) % NREQ;
`endif
        void'(exp_q.pop_front());
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] exp_grant,
                        output logic [ID_W-1:0] id, output logic [11:0] c, output int lat);
    int n;
    id = '0; c = '0; lat = 0;
    @(posedge clk); #1 req_valid = mask;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == 0 && n < 50);
    if (n >= 50) begin chk("grant_timeout", 1, 0); return; end
    chk("grant_onehot", req_ready, exp_grant);
    @(posedge clk); #1 req_valid = '0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 100);
    if (lat >= 100) begin chk("rsp_timeout", 1, 0); return; end
    id = rsp_id;
    c  = rsp_C;
    @(posedge clk);
  endtask

  task automatic drain();
    @(posedge clk); #1 req_valid = '0; rsp_ready = 1'b1;
    repeat (SETTLE + 8) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [ID_W-1:0] id;
  logic [11:0]     c;
  int              lat;
  int              n;
  int              exp_seq[5];

  initial begin
`ifdef ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 0, 1};
`endif
    rst_n = 1'b1; req_valid = '0; req_A = '0; req_B = '0; rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Lane model pinned to hand-derived values.
    chk("lane_f_000_000", lane_f(12'h000, 12'h000), 12'hFFF);
    chk("lane_f_FFF_FFF", lane_f(12'hFFF, 12'hFFF), 12'h000);
    chk("lane_f_000_FFF", lane_f(12'h000, 12'hFFF), 12'h001);

    // Single op on requester 1.
    req_A[12 +: 12] = 12'h000; req_B[12 +: 12] = 12'h000;
    run_op(3'b010, 3'b010, id, c, lat);
    chk("single_id", id, 1);
    chk("single_C", c, 12'hFFF);
    chk("single_latency", lat, SETTLE + 2);

    // Datapath through requester 0.
    req_A[0 +: 12] = 12'hFFF; req_B[0 +: 12] = 12'hFFF;
    run_op(3'b001, 3'b001, id, c, lat);
    chk("dp1_C", c, 12'h000);
    req_A[0 +: 12] = 12'h000; req_B[0 +: 12] = 12'hFFF;
    run_op(3'b001, 3'b001, id, c, lat);
    chk("dp2_C", c, 12'h001);
    chk("dp2_id", id, 0);

    // Reset mid-SETTLE with every requester asking.
    req_A[12 +: 12] = 12'hABC; req_B[12 +: 12] = 12'h123;
    @(posedge clk); #1 req_valid = 3'b111;
    @(negedge clk);
`ifdef ARB_FIXED_PRIO_EN
    chk("pre_reset_grant", req_ready, 3'b001);
`else
    chk("pre_reset_grant", req_ready, 3'b010);
`endif
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {req_ready, busy, rsp_valid, lane_A, lane_B, rsp_id, rsp_C}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Round-robin sequence with all requesters held.
    hs_ids.delete();
    n = 0;
    while (hs_ids.size() < 5 && n < 200) begin @(posedge clk); n++; end
    if (n >= 200) chk("rr_timeout", 1, 0);
    else for (int i = 0; i < 5; i++) chk($sformatf("rr_seq_%0d", i), hs_ids[i], exp_seq[i]);
    drain();

    // Backpressure for 10 cycles in RESP.
    @(posedge clk); #1 rsp_ready = 1'b0; req_valid = 3'b001;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == 0 && n < 50);
    chk("bp_grant", req_ready, 3'b001);
    @(posedge clk); #1 req_valid = 3'b111;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
    chk("bp_rsp_seen", rsp_valid, 1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold_ready", req_ready, 0);
      chk("bp_hold_valid", rsp_valid, 1);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_busy", busy, 0);
`ifdef ARB_FIXED_PRIO_EN
    chk("bp_next_grant", req_ready, 3'b001);
`else
    chk("bp_next_grant", req_ready, 3'b010);
`endif
    drain();

    // Randomised traffic with random response backpressure.
    repeat (600) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) req_valid = NREQ'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 1) == 1) req_A[12*i +: 12] = 12'($urandom);
        if ($urandom_range(0, 1) == 1) req_B[12*i +: 12] = 12'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
